// File: rtl/mux_scan_reg.sv
// Registered N-channel x W-bit multiplexer with DIRECT (sel-driven) and SCAN (dwell-stepped) modes.
// Outputs carry the source channel index plus valid/err flags, all one clock after sampling.
module mux_scan_reg #(
    parameter int W     = 4,
    parameter int N     = 4,
    parameter int SW    = 2,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [SW-1:0]    sel,
    input  logic [N*W-1:0]   din,
    output logic [W-1:0]     y,
    output logic [SW-1:0]    ch,
    output logic             valid,
    output logic             err
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic {
        ST_DIRECT = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_ptr;
    logic [DW-1:0]   r_dcnt;
    logic [W-1:0]    r_y;
    logic [SW-1:0]   r_ch;
    logic            r_valid;
    logic            r_err;

    state_t          w_state;
    logic [SW-1:0]   w_ptr;
    logic [DW-1:0]   w_dcnt;
    logic [W-1:0]    w_y;
    logic [SW-1:0]   w_ch;
    logic            w_valid;
    logic            w_err;
    logic [W-1:0]    w_sel_data;
    logic [W-1:0]    w_ptr_data;
    logic            w_sel_ok;
    logic            w_scan;

    // Channel selection for both the sel input and the scan pointer; illegal indices read as zero.
    always_comb begin
        w_sel_data = {W{1'b0}};
        w_ptr_data = {W{1'b0}};
        for (int k = 0; k < N; k++) begin
            w_sel_data = (sel   == SW'(k)) ? din[k*W +: W] : w_sel_data;
            w_ptr_data = (r_ptr == SW'(k)) ? din[k*W +: W] : w_ptr_data;
        end
        // Widened compare so N == 2**SW does not truncate to zero.
        w_sel_ok = ({1'b0, sel} < (SW+1)'(N));
    end

    // Next-state and next-output logic; hold is the default and valid drops unless a sample is taken.
    always_comb begin
        w_state = mode ? ST_SCAN : ST_DIRECT;
        w_ptr   = r_ptr;
        w_dcnt  = r_dcnt;
        w_y     = r_y;
        w_ch    = r_ch;
        w_valid = 1'b0;
        w_err   = r_err;
        w_scan  = 1'b0;

        case (r_state)
            ST_DIRECT: begin
                // Entering SCAN restarts the sweep at channel 0 on the following edge.
                if (mode) begin
                    w_ptr  = {SW{1'b0}};
                    w_dcnt = {DW{1'b0}};
                end else begin
                    w_ptr  = r_ptr;
                    w_dcnt = r_dcnt;
                end
            end
            ST_SCAN: begin
                w_scan = mode;
            end
            default: begin
                w_scan = 1'b0;
            end
        endcase

        if (en) begin
            if (w_scan) begin
                w_y     = w_ptr_data;
                w_ch    = r_ptr;
                w_valid = 1'b1;
                w_err   = 1'b0;
                if (r_dcnt == DW'(DWELL - 1)) begin
                    w_dcnt = {DW{1'b0}};
                    w_ptr  = (r_ptr == SW'(N - 1)) ? {SW{1'b0}} : r_ptr + SW'(1);
                end else begin
                    w_dcnt = r_dcnt + DW'(1);
                end
            end else if (w_sel_ok) begin
                w_y     = w_sel_data;
                w_ch    = sel;
                w_valid = 1'b1;
                w_err   = 1'b0;
            end else begin
                w_y     = {W{1'b0}};
                w_ch    = r_ch;
                w_valid = 1'b0;
                w_err   = 1'b1;
            end
        end else begin
            w_valid = 1'b0;
        end
    end

    // State and output registers with synchronous reset taking priority over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_DIRECT;
            r_ptr   <= {SW{1'b0}};
            r_dcnt  <= {DW{1'b0}};
            r_y     <= {W{1'b0}};
            r_ch    <= {SW{1'b0}};
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_dcnt  <= w_dcnt;
            r_y     <= w_y;
            r_ch    <= w_ch;
            r_valid <= w_valid;
            r_err   <= w_err;
        end
    end

    assign y     = r_y;
    assign ch    = r_ch;
    assign valid = r_valid;
    assign err   = r_err;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Bench for mux_scan_reg: a 4-channel/DWELL=4 build and a 3-channel/DWELL=1 build share stimulus
// and are checked every clock against a sample-count reference model.
module tb_mux_scan_reg;

    logic        clk = 1'b0;
    logic        rst, en, mode;
    logic [1:0]  sel;
    logic [15:0] din4;
    logic [11:0] din3;
    logic [3:0]  y4, y3;
    logic [1:0]  ch4, ch3;
    logic        valid4, valid3, err4, err3;

    int vecs = 0;
    int miss = 0;

    // Reference state per build: expected outputs, whether the previous edge left it in SCAN,
    // and the number of enabled SCAN samples taken since the sweep started.
    int m_y[2], m_ch[2], m_v[2], m_e[2], m_in[2], m_sc[2];

    always #5 clk = ~clk;

    mux_scan_reg #(.W(4), .N(4), .SW(2), .DWELL(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .din(din4),
        .y(y4), .ch(ch4), .valid(valid4), .err(err4));

    mux_scan_reg #(.W(4), .N(3), .SW(2), .DWELL(1)) dut3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .din(din3),
        .y(y3), .ch(ch3), .valid(valid3), .err(err3));

    task automatic model(input int d, input int nch, input int dwell, input logic [15:0] dv);
        int c;
        if (rst) begin
            m_y[d] = 0; m_ch[d] = 0; m_v[d] = 0; m_e[d] = 0; m_in[d] = 0; m_sc[d] = 0;
        end else begin
            if (m_in[d] == 0 && mode) m_sc[d] = 0;
            if (en) begin
                if (m_in[d] == 1 && mode) begin
                    c = (m_sc[d] / dwell) % nch;
                    m_y[d] = (dv >> (4 * c)) & 16'hF;
                    m_ch[d] = c; m_v[d] = 1; m_e[d] = 0;
                    m_sc[d] = m_sc[d] + 1;
                end else if (int'(sel) < nch) begin
                    m_y[d] = (dv >> (4 * int'(sel))) & 16'hF;
                    m_ch[d] = int'(sel); m_v[d] = 1; m_e[d] = 0;
                end else begin
                    m_y[d] = 0; m_v[d] = 0; m_e[d] = 1;
                end
            end else begin
                m_v[d] = 0;
            end
            m_in[d] = mode ? 1 : 0;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        vecs++;
        assert (act === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model(0, 4, 4, din4);
        model(1, 3, 1, {4'h0, din3});
        #1;
        chk("y4",  8'(y4),     8'(m_y[0]));
        chk("ch4", 8'(ch4),    8'(m_ch[0]));
        chk("v4",  8'(valid4), 8'(m_v[0]));
        chk("e4",  8'(err4),   8'(m_e[0]));
        chk("y3",  8'(y3),     8'(m_y[1]));
        chk("ch3", 8'(ch3),    8'(m_ch[1]));
        chk("v3",  8'(valid3), 8'(m_v[1]));
        chk("e3",  8'(err3),   8'(m_e[1]));
    endtask

    initial begin
        din4 = 16'hDCBA; din3 = 12'hCBA;
        rst = 1'b1; en = 1'b1; mode = 1'b1; sel = 2'd0;
        #2;
        // Reset held two clocks with en and SCAN requested.
        tick(); tick();
        chk("t1_y", 8'(y4), 8'h0);
        chk("t1_v", 8'(valid4), 8'h0);

        // DIRECT walk over all channels.
        rst = 1'b0; mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            tick();
            chk("t2_y", 8'(y4), 8'(10 + s));
        end

        // SCAN sweep: transition edge, then 17 samples including the wrap back to A.
        mode = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            tick();
            chk("t3_y", 8'(y4), 8'(10 + (i / 4) % 4));
        end

        // Restart sweep and pause mid-dwell on ch1.
        mode = 1'b0; tick();
        mode = 1'b1; tick();
        for (int i = 0; i < 6; i++) tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold_y", 8'(y4), 8'hB);
            chk("t4_hold_v", 8'(valid4), 8'h0);
        end
        en = 1'b1;
        tick(); chk("t4_b1", 8'(y4), 8'hB);
        tick(); chk("t4_b2", 8'(y4), 8'hB);
        tick(); chk("t4_c",  8'(y4), 8'hC);

        // Illegal select on the 3-channel build, then a legal one.
        mode = 1'b0; sel = 2'd3;
        tick();
        chk("t5_err", 8'(err3), 8'h1);
        chk("t5_y",   8'(y3),   8'h0);
        sel = 2'd2;
        tick();
        chk("t5_err0", 8'(err3), 8'h0);
        chk("t5_y2",   8'(y3),   8'hC);

        // Reset mid-SCAN on ch2, then the sweep restarts at ch0.
        mode = 1'b1; tick();
        for (int i = 0; i < 9; i++) tick();
        chk("t6_pre", 8'(ch4), 8'h2);
        rst = 1'b1; tick();
        chk("t6_y", 8'(y4), 8'h0);
        chk("t6_ch", 8'(ch4), 8'h0);
        rst = 1'b0; sel = 2'd1;
        tick();
        tick();
        chk("t6_ch0", 8'(ch4), 8'h0);
        chk("t6_y0", 8'(y4), 8'hA);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 59) == 0);
            en   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel  = 2'($urandom);
            din4 = 16'($urandom);
            din3 = 12'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
